// File: rtl/enemy_spawn_scheduler.sv
// Enemy slot spawn/destroy sequencer paced by the synchronized 4 Hz game tick.
// Optional macro SPAWN_RR_EN selects round-robin slot choice instead of fixed lowest-index priority.
module enemy_spawn_scheduler #(
    parameter int SPAWN_INTERVAL = 8,
    parameter int FIRST_DELAY    = 4,
    parameter int TOTAL_ENEMIES  = 20,
    parameter int MAX_ALIVE      = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clk_4hz_i,
    input  logic       game_start_i,
    input  logic       game_over_i,
    input  logic [3:0] tank_dead_i,
    output logic       tank1_en_o,
    output logic       tank2_en_o,
    output logic       tank3_en_o,
    output logic       tank4_en_o,
    output logic       spawn_pulse_o,
    output logic [1:0] spawn_slot_o,
    output logic [5:0] enemies_left_o,
    output logic       all_cleared_o
);

    localparam logic [3:0] INTERVAL    = 4'(SPAWN_INTERVAL);
    localparam logic [3:0] TIMER_START = (SPAWN_INTERVAL > FIRST_DELAY) ?
                                         4'(SPAWN_INTERVAL - FIRST_DELAY) : 4'd0;
    localparam logic [5:0] RESERVE     = 6'(TOTAL_ENEMIES);
    localparam logic [2:0] ALIVE_MAX   = 3'(MAX_ALIVE);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] en_q, en_d;
    logic       pulse_q, pulse_d;
    logic [1:0] slot_q, slot_d;
    logic [5:0] left_q, left_d;
    logic [3:0] timer_q, timer_d;

    // sync_q[1:0] is the two-flop synchronizer; sync_q[2] is the edge-detect history
    logic [2:0] sync_q;
    logic       tick_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 3'b000;
            tick_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[1:0], clk_4hz_i};
            tick_q <= sync_q[1] & ~sync_q[2];
        end
    end

    logic [2:0] alive_cnt;
    logic [3:0] free;
    logic [1:0] sel;
    logic       found;
    logic       spawn_ok;

    always_comb begin
        alive_cnt = 3'(en_q[0]) + 3'(en_q[1]) + 3'(en_q[2]) + 3'(en_q[3]);
        free      = ~en_q;
        sel       = 2'd0;
        found     = 1'b0;
`ifdef SPAWN_RR_EN
        for (int k = 1; k <= 4; k++) begin
            if (!found && free[slot_q + 2'(k)]) begin
                sel   = slot_q + 2'(k);
                found = 1'b1;
            end
        end
`else
        for (int i = 3; i >= 0; i--) begin
            if (free[i]) begin
                sel   = 2'(i);
                found = 1'b1;
            end
        end
`endif
        spawn_ok = (timer_q == INTERVAL) && (left_q != 6'd0) &&
                   (alive_cnt < ALIVE_MAX) && found;
    end

    always_comb begin
        state_d = state_q;
        en_d    = en_q;
        pulse_d = 1'b0;
        slot_d  = slot_q;
        left_d  = left_q;
        timer_d = timer_q;
        if (game_over_i) begin
            state_d = IDLE;
            en_d    = 4'b0000;
            slot_d  = 2'd0;
            left_d  = 6'd0;
            timer_d = 4'd0;
        end else if (game_start_i) begin
            state_d = RUN;
            en_d    = 4'b0000;
            slot_d  = 2'd0;
            left_d  = RESERVE;
            timer_d = TIMER_START;
        end else begin
            case (state_q)
                RUN: begin
                    en_d = en_q & ~tank_dead_i;
                    if (left_q == 6'd0 && en_q == 4'b0000) begin
                        state_d = DONE;
                    end
                    if (spawn_ok) begin
                        en_d[sel] = 1'b1;
                        pulse_d   = 1'b1;
                        slot_d    = sel;
                        left_d    = left_q - 6'd1;
                        timer_d   = 4'd0;
                    end else if (tick_q && timer_q != INTERVAL) begin
                        timer_d = timer_q + 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            en_q    <= 4'b0000;
            pulse_q <= 1'b0;
            slot_q  <= 2'd0;
            left_q  <= 6'd0;
            timer_q <= 4'd0;
        end else begin
            state_q <= state_d;
            en_q    <= en_d;
            pulse_q <= pulse_d;
            slot_q  <= slot_d;
            left_q  <= left_d;
            timer_q <= timer_d;
        end
    end

    assign tank1_en_o     = en_q[0];
    assign tank2_en_o     = en_q[1];
    assign tank3_en_o     = en_q[2];
    assign tank4_en_o     = en_q[3];
    assign spawn_pulse_o  = pulse_q;
    assign spawn_slot_o   = slot_q;
    assign enemies_left_o = left_q;
    assign all_cleared_o  = (state_q == DONE);

endmodule

// File: tb/tb_enemy_spawn_scheduler.sv
// Scoreboarded bench: a round-level reference model predicts spawns and slot states.
module tb_enemy_spawn_scheduler;
    localparam int SI = 2;
    localparam int FD = 1;
    localparam int TE = 5;
    localparam int MA = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       clk_4hz = 1'b0;
    logic       game_start = 1'b0;
    logic       game_over = 1'b0;
    logic [3:0] tank_dead = 4'b0000;
    logic       tank1_en, tank2_en, tank3_en, tank4_en;
    logic       spawn_pulse;
    logic [1:0] spawn_slot;
    logic [5:0] enemies_left;
    logic       all_cleared;

    enemy_spawn_scheduler #(
        .SPAWN_INTERVAL(SI), .FIRST_DELAY(FD), .TOTAL_ENEMIES(TE), .MAX_ALIVE(MA)
    ) dut (
        .clk(clk), .rst_n(rst_n), .clk_4hz_i(clk_4hz),
        .game_start_i(game_start), .game_over_i(game_over), .tank_dead_i(tank_dead),
        .tank1_en_o(tank1_en), .tank2_en_o(tank2_en), .tank3_en_o(tank3_en), .tank4_en_o(tank4_en),
        .spawn_pulse_o(spawn_pulse), .spawn_slot_o(spawn_slot),
        .enemies_left_o(enemies_left), .all_cleared_o(all_cleared)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit chk_en = 0;

    // Reference model: round phase (0 idle, 1 playing, 2 won), alive set, reserve,
    // ticks waited since the last spawn, last spawned slot.
    int m_phase, m_left, m_wait, m_last, cyc;
    bit m_alive[4];
    bit prev4;
    int rises[$];
    typedef struct { int slot; int left; } exp_t;
    exp_t sb[$];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    function automatic int pick();
`ifdef SPAWN_RR_EN
        for (int k = 1; k <= 4; k++)
            if (!m_alive[(m_last + k) % 4]) return (m_last + k) % 4;
`else
        for (int s = 0; s < 4; s++)
            if (!m_alive[s]) return s;
`endif
        return -1;
    endfunction

    function automatic int alive_count();
        int n = 0;
        for (int s = 0; s < 4; s++) n += int'(m_alive[s]);
        return n;
    endfunction

    function automatic int alive_vec();
        int v = 0;
        for (int s = 0; s < 4; s++) if (m_alive[s]) v += (1 << s);
        return v;
    endfunction

    task automatic model_reset();
        m_phase = 0; m_left = 0; m_wait = 0; m_last = 0; prev4 = 0;
        for (int s = 0; s < 4; s++) m_alive[s] = 0;
        rises.delete();
        sb.delete();
    endtask

    task automatic model_step();
        bit tick;
        int slot;
        bit ok;
        int n;
        cyc++;
        tick = 0;
        // a 4 Hz rising edge seen at edge c is acted upon as a tick at edge c+3
        if (rises.size() > 0 && rises[0] == cyc - 3) begin
            tick = 1;
            void'(rises.pop_front());
        end
        if (clk_4hz && !prev4) rises.push_back(cyc);
        prev4 = clk_4hz;
        if (game_over) begin
            m_phase = 0; m_left = 0; m_wait = 0; m_last = 0;
            for (int s = 0; s < 4; s++) m_alive[s] = 0;
        end else if (game_start) begin
            m_phase = 1; m_left = TE; m_wait = (SI > FD) ? SI - FD : 0; m_last = 0;
            for (int s = 0; s < 4; s++) m_alive[s] = 0;
        end else if (m_phase == 1) begin
            n = alive_count();
            slot = pick();
            ok = (m_wait == SI) && (m_left > 0) && (n < MA) && (slot >= 0);
            if (m_left == 0 && n == 0) m_phase = 2;
            for (int s = 0; s < 4; s++) if (tank_dead[s]) m_alive[s] = 0;
            if (ok) begin
                m_alive[slot] = 1;
                m_last = slot;
                m_left--;
                m_wait = 0;
                sb.push_back('{slot, m_left});
            end else if (tick) begin
                m_wait = (m_wait + 1 > SI) ? SI : m_wait + 1;
            end
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            if (rst_n) model_step();
        end
    end

    initial begin
        forever begin
            repeat ($urandom_range(4, 8)) @(negedge clk);
            clk_4hz = ~clk_4hz;
        end
    end

    int dut_vec;
    assign dut_vec = {28'd0, tank4_en, tank3_en, tank2_en, tank1_en};

    // per-cycle state comparison
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en && rst_n) begin
                chk("enables", dut_vec, alive_vec());
                chk("enemies_left", int'(enemies_left), m_left);
                chk("all_cleared", int'(all_cleared), int'(m_phase == 2));
            end
        end
    end

    // spawn monitor: pops the expected spawn whenever the DUT pulses
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (chk_en && rst_n && spawn_pulse) begin
                if (sb.size() == 0) begin
                    chk("unexpected_spawn", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("spawn_slot", int'(spawn_slot), e.slot);
                    chk("spawn_left", int'(enemies_left), e.left);
                end
            end
        end
    end

    task automatic wait_pulse(input string name, input int budget);
        bit got = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (spawn_pulse) begin
                got = 1;
                break;
            end
        end
        chk(name, int'(got), 1);
    endtask

    task automatic start_round();
        @(negedge clk); game_start = 1'b1;
        @(negedge clk); game_start = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_en"}, dut_vec, 0);
        chk({tag, "_pulse"}, int'(spawn_pulse), 0);
        chk({tag, "_slot"}, int'(spawn_slot), 0);
        chk({tag, "_left"}, int'(enemies_left), 0);
        chk({tag, "_cleared"}, int'(all_cleared), 0);
    endtask

    initial begin
        int pulses;
        bit got;
        int r;
        cyc = 0;
        model_reset();
        #2 rst_n = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        chk_reset_outputs("reset");
        rst_n = 1'b1;
        chk_en = 1;

        // first spawn and reserve countdown
        start_round();
        wait_pulse("first_spawn", 200);
`ifndef SPAWN_RR_EN
        chk("first_slot", int'(spawn_slot), 0);
`endif
        chk("first_left", int'(enemies_left), 4);
        got = 0;
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            if (dut_vec == 15 && enemies_left == 6'd1) begin
                got = 1;
                break;
            end
        end
        chk("four_alive", int'(got), 1);

        // full field: no spawn while blocked
        pulses = 0;
        repeat (110) begin
            @(negedge clk);
            if (spawn_pulse) pulses++;
        end
        chk("blocked_spawns", pulses, 0);
        tank_dead = 4'b0100;
        @(negedge clk); tank_dead = 4'b0000;
        chk("dead2_en3", int'(tank3_en), 0);
        @(negedge clk);
        chk("respawn_pulse", int'(spawn_pulse), 1);
        chk("respawn_slot", int'(spawn_slot), 2);
        chk("respawn_left", int'(enemies_left), 0);

        // clear the field
        tank_dead = 4'b1111;
        @(negedge clk); tank_dead = 4'b0000;
        chk("killall_en", dut_vec, 0);
        chk("killall_not_yet", int'(all_cleared), 0);
        @(negedge clk);
        chk("cleared", int'(all_cleared), 1);

        // restart, then a kill mask wider than the alive set
        start_round();
        chk("restart_cleared", int'(all_cleared), 0);
        chk("restart_left", int'(enemies_left), 5);
        wait_pulse("restart_spawn", 200);
        tank_dead = 4'b1111;
        @(negedge clk); tank_dead = 4'b0000;
        chk("wide_kill_en", dut_vec, 0);
        chk("wide_kill_left", int'(enemies_left), 4);

        // randomized play
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            r = $urandom_range(0, 199);
            game_over  = (r < 2) || (r == 5);
            game_start = (r >= 2 && r < 5) || (r == 5);
            tank_dead  = (r >= 10 && r < 30) ? 4'($urandom_range(1, 15)) : 4'b0000;
        end
        @(negedge clk);
        game_over = 1'b0; game_start = 1'b0; tank_dead = 4'b0000;

        // simultaneous over/start mid-round
        start_round();
        wait_pulse("pre_over_spawn", 200);
        game_over = 1'b1; game_start = 1'b1;
        @(negedge clk); game_over = 1'b0; game_start = 1'b0;
        chk_reset_outputs("over_start");

        // asynchronous reset mid-round
        start_round();
        wait_pulse("pre_reset_spawn", 200);
        #2 rst_n = 1'b0;
        model_reset();
        #1 chk_reset_outputs("async_reset");
        @(negedge clk); rst_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("sb_drained", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout actual=running expected=finished");
        $fatal(1);
    end
endmodule

// File: doc/enemy_spawn_scheduler.md
# enemy_spawn_scheduler

Sequences the four enemy tank slots of the battle field: decides when each slot's enable is raised (spawn) and lowered (destroyed), paced by the 4 Hz game tick. It enforces a spawn interval, a limit on simultaneously alive enemies and a finite enemy reserve, and flags the round cleared. Sits between the game-state logic (start/over, hit detection) and the four enemy tank movement/render modules, which consume `tank1_en`..`tank4_en`.

## Interface
- `SPAWN_INTERVAL`, 8: 4 Hz ticks between consecutive spawns (1..15).
- `FIRST_DELAY`, 4: ticks from `game_start` to first spawn (1..15).
- `TOTAL_ENEMIES`, 20: enemies in the reserve per round (1..63).
- `MAX_ALIVE`, 4: maximum simultaneously enabled slots (1..4).

- `clk` in 1: system clock; all logic on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `clk_4Hz` in 1: 4 Hz square wave from the clock divider; asynchronous to `clk`, synchronized internally.
- `game_start` in 1: one-cycle pulse, starts or restarts a round.
- `game_over` in 1: one-cycle pulse, aborts the round.
- `tank_dead` in 4: bit i pulses for one cycle when enemy slot i+1 is destroyed.
- `tank1_en`..`tank4_en` out 1 each: slot enables (registered).
- `spawn_pulse` out 1: one-cycle pulse on each spawn.
- `spawn_slot` out 2: index (0..3) of last spawned slot; valid with and held after `spawn_pulse`.
- `enemies_left` out 6: reserve still to be spawned.
- `all_cleared` out 1: level, round won.

## Operation
- Tick: `clk_4Hz` through 2-FF synchronizer, rising-edge detect -> one-cycle `tick`.
- States: IDLE, RUN, DONE.
- IDLE: all enables 0, `enemies_left`=0, timer 0. `game_start` -> RUN, `enemies_left`=`TOTAL_ENEMIES`, timer = `SPAWN_INTERVAL`-`FIRST_DELAY` (saturating at 0 minimum).
- RUN: timer increments on `tick`, saturates at `SPAWN_INTERVAL`. Spawn condition: timer==`SPAWN_INTERVAL` AND `enemies_left`>0 AND alive count (popcount of enables) < `MAX_ALIVE` AND at least one slot free. On spawn: selected slot enable<=1, `spawn_pulse`<=1, `spawn_slot`<=slot, `enemies_left`-=1, timer<=0.
- Free slot = enable currently 0 in the register; a slot cleared by `tank_dead` this cycle is free from the next cycle.
- `tank_dead[i]` with slot enabled: enable<=0 next cycle. With slot disabled: ignored.
- Blocked spawn (interval elapsed, no room): timer holds saturated; spawn fires the first cycle room exists.
- RUN -> DONE when `enemies_left`==0 and all enables 0. DONE: `all_cleared`=1.
- `game_over` in any state -> IDLE, all outputs to reset values next cycle. `game_start` in RUN or DONE -> full restart as from IDLE. `game_over` wins over `game_start` if simultaneous.

## Timing
- Reset values: all enables 0, `spawn_pulse` 0, `spawn_slot` 0, `enemies_left` 0, `all_cleared` 0, state IDLE, synchronizer 0.
- `clk_4Hz` rising edge -> `tick` 3 `clk` cycles later.
- Spawn condition true in cycle N -> enable and `spawn_pulse` high in N+1.
- `tank_dead` in cycle N -> enable low in N+1; slot spawnable earliest in N+1 evaluation, enable high N+2.
- Last enable falling in N -> `all_cleared` high in N+1.
- At most one spawn per cycle and per interval.
- Reset asserted mid-round: immediate return to reset values.

## Configuration
- `SPAWN_RR_EN` defined: round-robin slot selection, search starts at (`spawn_slot`+1) mod 4, wraps.
- Undefined: fixed priority, lowest-index free slot.

## Test plan
- Reset, then `game_start` with `FIRST_DELAY`=1, `SPAWN_INTERVAL`=2, `TOTAL_ENEMIES`=5 -> first spawn to slot 0 after 1 tick, then one spawn per 2 ticks; `enemies_left` 5->4->3->2->1.
- All four alive, `enemies_left`=1, hold 6 ticks -> no spawn; pulse `tank_dead[2]` -> `tank3_en` low next cycle, slot 2 spawned the cycle after, `enemies_left`=0.
- With `SPAWN_RR_EN` and slots 0,1 free, last `spawn_slot`=2 -> next spawn slot 0 via wrap; without macro -> slot 0 too; with last=0 and slots 0,3 free -> RR picks 3, fixed picks 0.
- `tank_dead`=4'b1111 with only slot 1 enabled -> only `tank2_en` clears, others stay 0, no counter change.
- Kill every enemy after reserve exhausted -> `all_cleared`=1 one cycle after last enable falls; `game_start` -> `all_cleared` 0, `enemies_left`=5.
- `game_over` and `game_start` same cycle mid-round -> IDLE, all enables 0; `rst_n` low mid-round -> outputs at reset values immediately.
